mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter and sequencer for the four-byte `memory_system`. It accepts read and write commands from two independent requesters. Each accepted command becomes a safe address/data/store sequence on the memory port, with `store` pulsed for exactly one cycle while address and data are stable. Read data is returned through a registered output. The block sits between the two datapath clients and the `memory_system` instance and owns that instance's `data`, `store` and `addr` inputs.

## Interface
- `DATA_W`, 8, width of one memory word
- `ADDR_W`, 2, address width; memory depth is 2**ADDR_W
- `clk` in 1, single clock; all state changes on its rising edge
- `rst_n` in 1, reset, asynchronous, active-low
- `req0` / `req1` in 1 each, command request from requester 0 / 1; held until the matching `done`
- `wr0` / `wr1` in 1 each, 1 = write, 0 = read; stable while the request is held
- `addr0` / `addr1` in ADDR_W each, target address; stable while the request is held
- `wdata0` / `wdata1` in DATA_W each, write data; stable while the request is held
- `done0` / `done1` out 1 each, one-cycle completion pulse to requester 0 / 1
- `rdata` out DATA_W, read result, valid in the `done` cycle of a read, then held
- `busy` out 1, high in every state except IDLE
- `mem_data` out DATA_W, drives `memory_system.data`
- `mem_store` out 1, drives `memory_system.store`
- `mem_addr` out ADDR_W, drives `memory_system.addr`
- `mem_rdata` in DATA_W, from `memory_system.memory`

## Operation
- States: IDLE, SETUP, STROBE, HOLD, RESP.
- **IDLE**
  - If any request is high, pick a winner.
  - Latch the winner's wr, addr and wdata into the command registers, then go to SETUP.
  - If no request is high, stay in IDLE.
- **SETUP**
  - `mem_addr` and `mem_data` come from the command registers; `mem_store` = 0.
  - Write: go to STROBE.
  - Read: capture `mem_rdata` into `rdata` on this edge, then go to RESP.
- **STROBE** (writes only): `mem_store` = 1 for exactly this cycle; address and data unchanged. Go to HOLD.
- **HOLD** (writes only): `mem_store` = 0; address and data still held. Go to RESP.
- **RESP**
  - Assert `done` for the winner only; go to IDLE.
  - Requests are not sampled in RESP. A request still high when IDLE is re-entered counts as a new command.
- **Arbitration**
  - Only one request high: it wins.
  - Both high: resolved per Configuration.
  - A request is never dropped. The losing request stays pending and is served after the current command's RESP.
- **Registered outputs**
  - `mem_addr` and `mem_data` stay at their last values in IDLE; they do not follow the requesters.
  - `rdata` changes only on read captures.
- Requester inputs are ignored outside IDLE. Changing them mid-command has no effect.
- **Reset values:** state IDLE, `done0`/`done1` 0, `busy` 0, `mem_store` 0, `mem_addr` 0, `mem_data` 0, `rdata` 0, last-winner pointer = 1.
- **Reset mid-operation:** `mem_store` drops to 0 immediately (asynchronous). No `done` is issued; the interrupted command is lost. A write interrupted in STROBE may or may not have updated memory.

## Timing
- Request sampled high at edge k (state IDLE).
- Write: SETUP k+1, STROBE k+2, HOLD k+3, RESP/`done` k+4. Latency 4 cycles.
- Read: SETUP k+1, RESP/`done` k+2, `rdata` valid in the same cycle. Latency 2 cycles.
- Throughput to one port: the next command is sampled one cycle after RESP. Minimum spacing is 5 cycles per write and 3 per read.
- `mem_store` is high for exactly 1 cycle per write and never high outside STROBE. Address and data are stable one cycle before and one cycle after the strobe.
- `done0` and `done1` are never high together.

## Configuration
- Macro: `MEM_ARBITER_RR_EN`.
- Defined: round-robin. On a tie, the requester that did not win last time is granted, and the last-winner pointer updates on every grant. After reset the pointer is 1, so requester 0 wins the first tie.
- Undefined: fixed priority. `req0` always wins ties, the pointer register is not built, and `req1` may starve.

## Structure
- Package `mem_arbiter_pkg` holds:
  - state enum `mem_arb_state_t` (IDLE, SETUP, STROBE, HOLD, RESP)
  - default width constants `MEM_DATA_W` = 8, `MEM_ADDR_W` = 2
  - the requester-index type
- One sub-module, `mem_arb_pick`: a combinational two-way picker taking `req0`, `req1` and the last-winner pointer and returning the winner index. Its round-robin logic is compiled under `MEM_ARBITER_RR_EN`.
- Top level holds the FSM, the command registers and the `rdata` register. It is integrated alongside a `memory_system` instance in the bench.

## Test plan
- Single write: after reset, `req0`=1, `wr0`=1, `addr0`=2, `wdata0`=0xA5 -> `mem_store` high only in cycle k+2 with `mem_addr`=2 and `mem_data`=0xA5; `done0` at k+4.
- Read-back: then `req1`=1, `wr1`=0, `addr1`=2 -> `done1` at k+2 with `rdata`=0xA5; `mem_store` stays 0 throughout.
- Tie, RR build: `req0` and `req1` both held high, each writing 0x11 / 0x22 to addr 0 -> grants alternate 0, 1, 0, 1. Reading addr 0 after an odd number of grants returns 0x11.
- Tie, fixed build (macro undefined): both held high for 4 commands -> `done0` only, `done1` never.
- Reset mid-write: assert `rst_n`=0 during STROBE -> `mem_store`=0 immediately; `busy`, `done0` and `done1` all 0; a new read after release completes in 2 cycles.
- All addresses: write 0x10..0x13 to addr 0..3 via alternating ports, then read all four -> 0x10, 0x11, 0x12, 0x13 with no aliasing.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and default widths for the two-port memory arbiter.
package mem_arbiter_pkg;

  localparam int MEM_DATA_W = 8;
  localparam int MEM_ADDR_W = 2;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    RESP
  } mem_arb_state_t;

  // Index of a requester: 0 or 1.
  typedef logic req_idx_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational two-way picker. With MEM_ARBITER_RR_EN defined a tie goes to the
// requester that did not win last; otherwise requester 0 always wins a tie.
module mem_arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
`ifdef MEM_ARBITER_RR_EN
  input  logic last,
`endif
  output logic winner
);

  always_comb begin
    winner = 1'b0;
    if (req0 && req1) begin
`ifdef MEM_ARBITER_RR_EN
      winner = ~last;
`else
      winner = 1'b0;
`endif
    end else if (req1) begin
      winner = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer for memory_system: IDLE, SETUP, STROBE, HOLD, RESP.
// Build option MEM_ARBITER_RR_EN selects round-robin tie breaking instead of fixed priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_W = MEM_DATA_W,
  parameter int ADDR_W = MEM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              wr0,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_store,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata
);

  mem_arb_state_t    state_q, state_d;
  logic              wr_q, wr_d;
  req_idx_t          win_q, win_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic              mem_store_q, mem_store_d;
  logic              done0_q, done0_d;
  logic              done1_q, done1_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  req_idx_t          winner;

`ifdef MEM_ARBITER_RR_EN
  req_idx_t          last_q, last_d;

  mem_arb_pick u_pick (
    .req0   (req0),
    .req1   (req1),
    .last   (last_q),
    .winner (winner)
  );
`else
  mem_arb_pick u_pick (
    .req0   (req0),
    .req1   (req1),
    .winner (winner)
  );
`endif

  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    win_d       = win_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    mem_store_d = 1'b0;
    done0_d     = 1'b0;
    done1_d     = 1'b0;
    busy_d      = busy_q;
    rdata_d     = rdata_q;
`ifdef MEM_ARBITER_RR_EN
    last_d      = last_q;
`endif
    case (state_q)
      IDLE: begin
        // The memory port registers double as the command registers, so the
        // address and data are already stable on the first SETUP cycle.
        if (req0 || req1) begin
          wr_d       = winner ? wr1 : wr0;
          mem_addr_d = winner ? addr1 : addr0;
          mem_data_d = winner ? wdata1 : wdata0;
          win_d      = winner;
          busy_d     = 1'b1;
          state_d    = SETUP;
`ifdef MEM_ARBITER_RR_EN
          last_d     = winner;
`endif
        end
      end
      SETUP: begin
        if (wr_q) begin
          mem_store_d = 1'b1;
          state_d     = STROBE;
        end else begin
          rdata_d = mem_rdata;
          done0_d = ~win_q;
          done1_d = win_q;
          state_d = RESP;
        end
      end
      STROBE: begin
        state_d = HOLD;
      end
      HOLD: begin
        done0_d = ~win_q;
        done1_d = win_q;
        state_d = RESP;
      end
      RESP: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_q        <= 1'b0;
      win_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      mem_store_q <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      busy_q      <= 1'b0;
      rdata_q     <= '0;
`ifdef MEM_ARBITER_RR_EN
      last_q      <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      win_q       <= win_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      mem_store_q <= mem_store_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
      busy_q      <= busy_d;
      rdata_q     <= rdata_d;
`ifdef MEM_ARBITER_RR_EN
      last_q      <= last_d;
`endif
    end
  end

  assign done0     = done0_q;
  assign done1     = done1_q;
  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign mem_data  = mem_data_q;
  assign mem_store = mem_store_q;
  assign mem_addr  = mem_addr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural four-byte memory_system beside it.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0, wr0 = 1'b0, wr1 = 1'b0;
  logic [1:0] addr0 = '0, addr1 = '0;
  logic [7:0] wdata0 = '0, wdata1 = '0;
  logic       done0, done1, busy, mem_store;
  logic [7:0] rdata, mem_data, mem_rdata;
  logic [1:0] mem_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .req1      (req1),
    .wr0       (wr0),
    .wr1       (wr1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .done0     (done0),
    .done1     (done1),
    .rdata     (rdata),
    .busy      (busy),
    .mem_data  (mem_data),
    .mem_store (mem_store),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata)
  );

  // memory_system stand-in: four bytes, written on a clock edge with store high.
  logic [7:0] mem_array [4];
  always @(posedge clk) if (mem_store) mem_array[mem_addr] <= mem_data;
  assign mem_rdata = mem_array[mem_addr];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("done_exclusive", int'(done0 & done1), 0);
      chk("store_needs_busy", int'(mem_store & ~busy), 0);
    end
  end

  typedef struct {
    int         port;
    logic       wr;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;

  task automatic do_cmd(input int port, input logic wr, input logic [1:0] a,
                        input logic [7:0] d, input logic [7:0] exp_rd);
    int n = 0;
    int stores = 0;
    int dport = -1;
    bit got = 0;
    @(negedge clk);
    if (port == 0) begin req0 = 1; wr0 = wr; addr0 = a; wdata0 = d; end
    else           begin req1 = 1; wr1 = wr; addr1 = a; wdata1 = d; end
    while (!got && n < 20) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (n == 1) chk("busy_in_cmd", int'(busy), 1);
      if (mem_store) begin
        stores++;
        chk("store_cycle", n, 2);
        chk("store_addr", int'(mem_addr), int'(a));
        chk("store_data", int'(mem_data), int'(d));
      end
      if (done0 || done1) begin
        got = 1;
        dport = done1 ? 1 : 0;
      end
    end
    req0 = 0;
    req1 = 0;
    chk("done_seen", int'(got), 1);
    chk("done_port", dport, port);
    chk("latency", n, wr ? 4 : 2);
    chk("store_count", stores, wr ? 1 : 0);
    if (!wr) chk("rdata", int'(rdata), int'(exp_rd));
    $display("cmd port=%0d %s addr=%0d wdata=0x%02h -> done_port=%0d latency=%0d rdata=0x%02h",
             port, wr ? "WR" : "RD", a, d, dport, n, rdata);
  endtask

  initial begin
    vec_t vecs [10];
    int   n;
    int   seq [4];
    int   dcount;
    logic [7:0] tie_exp;

    vecs[0] = '{0, 1'b1, 2'd2, 8'hA5, 8'h00};
    vecs[1] = '{1, 1'b0, 2'd2, 8'h00, 8'hA5};
    vecs[2] = '{0, 1'b1, 2'd0, 8'h10, 8'h00};
    vecs[3] = '{1, 1'b1, 2'd1, 8'h11, 8'h00};
    vecs[4] = '{0, 1'b1, 2'd2, 8'h12, 8'h00};
    vecs[5] = '{1, 1'b1, 2'd3, 8'h13, 8'h00};
    vecs[6] = '{1, 1'b0, 2'd0, 8'h00, 8'h10};
    vecs[7] = '{0, 1'b0, 2'd1, 8'h00, 8'h11};
    vecs[8] = '{1, 1'b0, 2'd2, 8'h00, 8'h12};
    vecs[9] = '{0, 1'b0, 2'd3, 8'h00, 8'h13};

    repeat (2) @(negedge clk);
    chk("rst_done0", int'(done0), 0);
    chk("rst_done1", int'(done1), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_store", int'(mem_store), 0);
    chk("rst_addr", int'(mem_addr), 0);
    chk("rst_data", int'(mem_data), 0);
    chk("rst_rdata", int'(rdata), 0);
    rst_n = 1;

    for (int i = 0; i < 10; i++)
      do_cmd(vecs[i].port, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);

    // Idle registers must not follow the requester inputs.
    @(negedge clk);
    addr0 = 2'd1; wdata0 = 8'hFF; addr1 = 2'd0; wdata1 = 8'hEE;
    repeat (2) @(negedge clk);
    chk("idle_busy", int'(busy), 0);
    chk("idle_addr_held", int'(mem_addr), 3);
    chk("idle_data_held", int'(mem_data), 0);
    chk("idle_rdata_held", int'(rdata), 8'h13);
    $display("idle hold: mem_addr=%0d mem_data=0x%02h rdata=0x%02h", mem_addr, mem_data, rdata);

    // Reset during STROBE.
    req0 = 1; wr0 = 1; addr0 = 2'd1; wdata0 = 8'h55;
    n = 0;
    while (!mem_store && n < 10) begin
      @(posedge clk); @(negedge clk); n++;
    end
    chk("strobe_reached", int'(mem_store), 1);
    req0 = 0;
    #1 rst_n = 0;
    #1;
    chk("rst_mid_store", int'(mem_store), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_done0", int'(done0), 0);
    chk("rst_mid_done1", int'(done1), 0);
    $display("reset mid-write: store=%0b busy=%0b done0=%0b done1=%0b", mem_store, busy, done0, done1);
    @(negedge clk);
    rst_n = 1;
    do_cmd(1, 1'b0, 2'd0, 8'h00, 8'h10);

    // Tie: both requesters hold write requests to address 0.
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    req0 = 1; wr0 = 1; addr0 = 2'd0; wdata0 = 8'h11;
    req1 = 1; wr1 = 1; addr1 = 2'd0; wdata1 = 8'h22;
    dcount = 0;
    n = 0;
    while (dcount < 4 && n < 60) begin
      @(posedge clk); @(negedge clk); n++;
      if (done0 || done1) begin
        seq[dcount] = done1 ? 1 : 0;
        dcount++;
      end
    end
    req0 = 0; req1 = 0;
    chk("tie_done_count", dcount, 4);
    for (int i = 0; i < dcount; i++) begin
`ifdef MEM_ARBITER_RR_EN
      chk("tie_grant", seq[i], i % 2);
`else
      chk("tie_grant", seq[i], 0);
`endif
      $display("tie grant %0d -> port %0d", i, seq[i]);
    end
`ifdef MEM_ARBITER_RR_EN
    tie_exp = 8'h22;
`else
    tie_exp = 8'h11;
`endif
    do_cmd(0, 1'b0, 2'd0, 8'h00, tie_exp);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
